// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing a multicycle MIPS datapath, with retire counter and illegal-op flag
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_pcwrite, w_branch, w_retire;
  logic [2:0]       w_funct_alu;

  assign state   = r_state;
  assign retired = r_retired;
  assign w_funct_alu = Funct == 6'b100010 ? 3'b110 :
                       Funct == 6'b100100 ? 3'b000 :
                       Funct == 6'b100101 ? 3'b001 :
                       Funct == 6'b101010 ? 3'b111 :
                       Funct == 6'b100111 ? 3'b100 : 3'b010;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  // Reset gates every output so an aborted instruction never writes anything.
  always_comb begin
    w_next     = FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    illegal_op = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_retire   = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          w_next     = DECODE;
          ALUSrcB    = 2'b01;
          ALUControl = 3'b010;
          IRWrite    = 1'b1;
          w_pcwrite  = 1'b1;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = 3'b010;
          w_next     = (Op == 6'b100011 || Op == 6'b101011) ? MEMADR :
                       (Op == 6'b000000 && Funct != 6'b000000) ? EXECUTE :
                       Op == 6'b000100 ? BRANCH :
                       Op == 6'b001000 ? ADDIEXEC :
                       Op == 6'b000010 ? JUMP : FETCH;
          illegal_op = !(Op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
          w_retire   = w_next == FETCH;
        end
        MEMADR: begin
          w_next     = Op == 6'b100011 ? MEMRD : MEMWR;
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = 3'b010;
        end
        MEMRD: begin
          w_next = MEMWB;
          IorD   = 1'b1;
        end
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          w_retire = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          w_retire = 1'b1;
        end
        EXECUTE: begin
          w_next     = ALUWB;
          ALUSrcA    = 1'b1;
          ALUControl = w_funct_alu;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          w_retire = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = 3'b110;
          PCSrc      = 2'b01;
          w_branch   = 1'b1;
          w_retire   = 1'b1;
        end
        ADDIEXEC: begin
          w_next     = ADDIWB;
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = 3'b010;
        end
        ADDIWB: begin
          RegWrite = 1'b1;
          w_retire = 1'b1;
        end
        JUMP: begin
          PCSrc     = 2'b10;
          w_pcwrite = 1'b1;
          w_retire  = 1'b1;
        end
        default: w_next = FETCH;
      endcase
    end
  end

  assign PCEn = w_pcwrite | (w_branch & Zero);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed sequence of instructions checking per-state controls and the retire counter
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal_op;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic [3:0] retired;
  logic [15:0] ctrl;
  logic [3:0]  exp_ret;
  int total = 0;
  int bad = 0;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .state(state),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  // Bit layout: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB[2] ALUControl[3] PCSrc[2] PCEn illegal_op
  assign ctrl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] c);
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
    chk({tag, ".ctrl"}, {16'd0, ctrl}, {16'd0, c});
    @(posedge clk);
    #1;
  endtask

  task automatic retire_chk(input string tag);
    exp_ret = exp_ret + 4'd1;
    chk({tag, ".retired"}, {28'd0, retired}, {28'd0, exp_ret});
  endtask

  initial begin
    reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; exp_ret = 4'd0;
    @(posedge clk); @(posedge clk); #2;
    chk("rst.state", {28'd0, state}, 32'd0);
    chk("rst.ctrl", {16'd0, ctrl}, 32'd0);
    chk("rst.retired", {28'd0, retired}, 32'd0);
    reset = 1'b0;
    Op = 6'b100011;
    cyc("lw.f", 4'd0, 16'h20A2);
    chk("first.retired", {28'd0, retired}, 32'd0);
    cyc("lw.d", 4'd1, 16'h01A0);
    cyc("lw.a", 4'd2, 16'h0320);
    cyc("lw.r", 4'd3, 16'h8000);
    cyc("lw.w", 4'd4, 16'h0C00);
    retire_chk("lw");
    Op = 6'b101011;
    cyc("sw.f", 4'd0, 16'h20A2);
    cyc("sw.d", 4'd1, 16'h01A0);
    cyc("sw.a", 4'd2, 16'h0320);
    cyc("sw.w", 4'd5, 16'hC000);
    retire_chk("sw");
    Op = 6'b000000; Funct = 6'b101010;
    cyc("slt.f", 4'd0, 16'h20A2);
    cyc("slt.d", 4'd1, 16'h01A0);
    cyc("slt.e", 4'd6, 16'h0270);
    cyc("slt.w", 4'd7, 16'h1400);
    retire_chk("slt");
    Funct = 6'b100111;
    cyc("nor.f", 4'd0, 16'h20A2);
    cyc("nor.d", 4'd1, 16'h01A0);
    cyc("nor.e", 4'd6, 16'h0240);
    cyc("nor.w", 4'd7, 16'h1400);
    retire_chk("nor");
    Funct = 6'b000001;
    cyc("unk.f", 4'd0, 16'h20A2);
    cyc("unk.d", 4'd1, 16'h01A0);
    cyc("unk.e", 4'd6, 16'h0220);
    cyc("unk.w", 4'd7, 16'h1400);
    retire_chk("unkfunct");
    Funct = 6'b000000;
    cyc("nop.f", 4'd0, 16'h20A2);
    cyc("nop.d", 4'd1, 16'h01A0);
    retire_chk("nop");
    Op = 6'b000100; Zero = 1'b1;
    cyc("beqt.f", 4'd0, 16'h20A2);
    cyc("beqt.d", 4'd1, 16'h01A0);
    cyc("beqt.b", 4'd8, 16'h0266);
    retire_chk("beqt");
    Zero = 1'b0;
    cyc("beqn.f", 4'd0, 16'h20A2);
    cyc("beqn.d", 4'd1, 16'h01A0);
    cyc("beqn.b", 4'd8, 16'h0264);
    retire_chk("beqn");
    Op = 6'b000010;
    cyc("j.f", 4'd0, 16'h20A2);
    cyc("j.d", 4'd1, 16'h01A0);
    cyc("j.j", 4'd11, 16'h000A);
    retire_chk("j");
    Op = 6'b111111;
    cyc("ill.f", 4'd0, 16'h20A2);
    cyc("ill.d", 4'd1, 16'h01A1);
    retire_chk("ill");
    Op = 6'b001000;
    cyc("addi.f", 4'd0, 16'h20A2);
    cyc("addi.d", 4'd1, 16'h01A0);
    cyc("addi.e", 4'd9, 16'h0320);
    cyc("addi.w", 4'd10, 16'h0400);
    retire_chk("addi");
    Op = 6'b100011;
    cyc("abort.f", 4'd0, 16'h20A2);
    cyc("abort.d", 4'd1, 16'h01A0);
    cyc("abort.a", 4'd2, 16'h0320);
    chk("abort.inrd", {28'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    chk("abort.ctrl", {16'd0, ctrl}, 32'd0);
    @(posedge clk); #1;
    chk("abort.ctrl2", {16'd0, ctrl}, 32'd0);
    chk("abort.state", {28'd0, state}, 32'd0);
    chk("abort.retired", {28'd0, retired}, 32'd0);
    exp_ret = 4'd0;
    reset = 1'b0;
    Op = 6'b000000; Funct = 6'b000000;
    cyc("rel.f", 4'd0, 16'h20A2);
    cyc("rel.d", 4'd1, 16'h01A0);
    retire_chk("rel");
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); @(posedge clk); #1;
      exp_ret = exp_ret + 4'd1;
    end
    chk("wrap.full", {28'd0, retired}, 32'd15);
    Op = 6'b000010;
    cyc("wrap.f", 4'd0, 16'h20A2);
    cyc("wrap.d", 4'd1, 16'h01A0);
    cyc("wrap.j", 4'd11, 16'h000A);
    chk("wrap.zero", {28'd0, retired}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: a single shared memory, an IR/PC enable, one ALU reused for PC+4, branch target and execution.
- Replaces the combinational ControlUnit when the core moves from single-cycle to multicycle.
- Issues per-cycle mux selects, write enables and ALUControl from the latched instruction fields and the ALU Zero flag.
- Counts retired instructions and flags unsupported opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Op  in  6  Instr[31:26] from the IR
- Funct  in  6  Instr[5:0] from the IR
- Zero  in  1  ALU zero flag
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR load enable
- RegDst  out  1  write register select: 0=rt, 1=rd
- MemtoReg  out  1  writeback select: 0=ALUOut, 1=Data
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  SrcA select: 0=PC, 1=A
- ALUSrcB  out  2  SrcB select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor
- PCSrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- PCEn  out  1  PC load enable = PCWrite | (Branch & Zero)
- state  out  4  current state, for debug
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported Op
- retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: reset is sampled on the rising clk edge. The next state is FETCH and retired is 0.
- While reset is high, every control output is forced to 0, including PCEn, IRWrite, MemWrite, RegWrite and illegal_op.
- After reset is released, the first active cycle is FETCH.
- Reset asserted mid-instruction aborts the instruction. No write enable is asserted in the reset cycle.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - Unused encodings go to FETCH on the next edge, with all outputs 0.
- Outputs per state. Any signal not listed is 0.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (computes the branch target into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct:
    - 100000 -> 010; 100010 -> 110; 100100 -> 000
    - 100101 -> 001; 101010 -> 111; 100111 -> 100
    - any other Funct -> 010
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by Op:
    - 100011 or 101011 -> MEMADR
    - 000000 with Funct!=000000 -> EXECUTE
    - 000000 with Funct=000000 (NOP) -> FETCH
    - 000100 -> BRANCH
    - 001000 -> ADDIEXEC
    - 000010 -> JUMP
    - any other Op -> FETCH, with illegal_op=1 for the DECODE cycle
  - MEMADR -> MEMRD if Op=100011, otherwise MEMWR.
  - MEMRD->MEMWB. EXECUTE->ALUWB. ADDIEXEC->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP -> FETCH.
- Latency in cycles, FETCH included: lw 5; sw, R-type and addi 4; beq and j 3; NOP and illegal 2.
- Op and Funct are treated as stable from DECODE onward, because the IR is loaded only in FETCH.
- retired increments by 1 on the clock edge leaving any of:
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP
  - DECODE when the next state is FETCH (NOP or illegal)
- retired wraps from all-ones to 0. Reset overrides the increment.
- BRANCH: PCEn follows Zero combinationally in the same cycle. A not-taken beq still retires.

Test Plan:
- Hold reset 2 cycles, then release -> outputs all 0 during reset; cycle 1 after release: state=0, IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010; retired=0.
- Op=100011 (lw) -> states 0,1,2,3,4; IorD=1 in state 3; RegWrite=1 with MemtoReg=1, RegDst=0 in state 4; retired increments by 1 after 5 cycles. sw (Op=101011) -> 0,1,2,5 with MemWrite=1 only in state 5.
- Op=000000, Funct=101010 -> EXECUTE has ALUControl=111; ALUWB has RegDst=1, RegWrite=1. Funct=100111 -> ALUControl=100. Funct=000000 -> 0,1,0 with no RegWrite; retired still increments.
- Op=000100 with Zero=1 -> BRANCH has PCEn=1, PCSrc=01. Same with Zero=0 -> PCEn=0. Both take 3 cycles and retire.
- Op=000010 -> JUMP has PCEn=1, PCSrc=10. Op=111111 -> illegal_op=1 for exactly the DECODE cycle, then FETCH; retired increments.
- Assert reset during MEMRD of an lw -> no RegWrite or MemWrite pulse, retired=0 afterwards, and FETCH is the first cycle after release. Force retired to all-ones with CNT_W=4, complete one instruction -> retired=0.
